mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the single synchronous-read memory between the core's instruction-fetch path and its load/store path. It sits between the core's fetch/LSU request ports and the `memory` instance, issues at most one memory access per cycle, and routes each 1-cycle-latency response back to the requester that owns it. A starvation guard prevents back-to-back data traffic from stalling fetch indefinitely.

## Interface
- `ADDR_W`, 32, address width (byte address)
- `DATA_W`, 32, data width; `DATA_W/8` strobe bits
- `MAX_WAIT`, 4, cycles fetch may be refused before it is forced to win (1..15)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request, held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch read data valid
- `if_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  data request, held until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_wstrb`  in  DATA_W/8  byte enables for store
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  load data valid / store completion
- `d_rdata`  out  DATA_W  load data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_wstrb`  out  DATA_W/8  memory byte enables
- `mem_rdata`  in  DATA_W  memory read data, valid 1 cycle after `mem_en`

## Operation
- Each cycle the arbiter selects a winner among asserted requests; winner's `*_gnt`=1 combinationally; `mem_*` driven combinationally from winner's inputs. No request → `mem_en`=0, `mem_we`=0.
- Fetch accesses always `mem_we`=0, `mem_wstrb`=0.
- Registered `owner` (NONE/IF/D) records the winner; next cycle the owner's `*_rvalid`=1. Stores also produce `d_rvalid` (completion; `d_rdata` don't-care).
- `if_rdata` and `d_rdata` both carry `mem_rdata` directly; only `*_rvalid` qualifies.
- Fixed-priority mode: data wins ties unless `wait_cnt` == `MAX_WAIT`, then fetch wins.
- `wait_cnt` (4 bits): +1 each cycle `if_req`=1 and `if_gnt`=0, saturating at `MAX_WAIT`; cleared on `if_gnt` or `if_req`=0.
- Requester drops or changes `req`/address only after its `gnt`; a new request may be raised the same cycle its `rvalid` arrives.

## Timing
- Grant latency 0 (same cycle as request if uncontested); response latency exactly 1 cycle after grant.
- Throughput: one access per cycle; back-to-back grants allowed, response of access N coincides with grant of N+1.
- Reset: `owner`=NONE, `wait_cnt`=0, `rr_last`=D; while `rst`=1 all `*_gnt`, `*_rvalid`, `mem_en`, `mem_we` forced 0.
- Reset asserted with a response pending: response dropped, no `rvalid` after release.
- Both requests in same cycle: exactly one `gnt`; loser's request persists to next cycle.
- `if_rvalid` and `d_rvalid` never both 1.

## Configuration
- `MEM_ARB_RR_EN` defined: ties resolved round-robin via `rr_last` (winner = opposite of last grant; updated on every grant); `wait_cnt` held at 0, `MAX_WAIT` ignored.
- Not defined: fixed data priority with `MAX_WAIT` starvation guard as above.

## Test plan
- Fetch only, `if_addr`=0x0 with mem word 0x00000513 → `if_gnt` cycle T, `if_rvalid`=1 and `if_rdata`=0x00000513 at T+1, `mem_we`=0.
- Simultaneous `if_req` and `d_req` load 0x100 (fixed mode) → `d_gnt` at T, `if_gnt` at T+1; `d_rvalid` T+1, `if_rvalid` T+2.
- `d_req` held continuously, `if_req` held, `MAX_WAIT`=4 → `if_gnt` at 5th cycle of fetch wait, data resumes next cycle.
- Store `d_addr`=0x200, `d_wdata`=0xDEADBEEF, `d_wstrb`=0x3 → `mem_we`=1, `mem_wstrb`=0x3 in grant cycle; later load reads 0x????BEEF with upper bytes unchanged; `d_rvalid` at T+1.
- `rst` pulsed in cycle after a fetch grant → no `if_rvalid`; outputs 0 during reset; arbitration correct after release.
- With `MEM_ARB_RR_EN`, both requests held 6 cycles → grants alternate IF, D, IF, D, IF, D.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one synchronous-read memory between fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data wins ties with a MAX_WAIT fetch starvation guard.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e       owner_q;
    owner_e       owner_d;
    logic [3:0]   wait_cnt_q;
    logic [3:0]   wait_cnt_d;
    logic         pick_if_s;
    logic         pick_d_s;

`ifdef MEM_ARB_RR_EN
    typedef enum logic {
        RR_IF = 1'b0,
        RR_D  = 1'b1
    } rr_e;

    rr_e          rr_last_q;
    rr_e          rr_last_d;
`endif

    // Winner selection; nothing is granted while reset is asserted.
    always_comb begin
        pick_if_s = 1'b0;
        pick_d_s  = 1'b0;
        if (rst) begin
            pick_if_s = 1'b0;
            pick_d_s  = 1'b0;
        end else if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            if (rr_last_q == RR_D) begin
                pick_if_s = 1'b1;
            end else begin
                pick_d_s = 1'b1;
            end
`else
            if (wait_cnt_q == MAX_WAIT_C) begin
                pick_if_s = 1'b1;
            end else begin
                pick_d_s = 1'b1;
            end
`endif
        end else if (if_req) begin
            pick_if_s = 1'b1;
        end else if (d_req) begin
            pick_d_s = 1'b1;
        end else begin
            pick_if_s = 1'b0;
            pick_d_s  = 1'b0;
        end
    end

    assign if_gnt = pick_if_s;
    assign d_gnt  = pick_d_s;

    // Memory port steering; fetch is always a full-word read.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        mem_wstrb = {STRB_W{1'b0}};
        if (pick_if_s) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (pick_d_s) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Next-state: response owner, fetch wait counter and round-robin pointer.
    always_comb begin
        owner_d    = OWN_NONE;
        wait_cnt_d = 4'd0;
        if (pick_if_s) begin
            owner_d = OWN_IF;
        end else if (pick_d_s) begin
            owner_d = OWN_D;
        end else begin
            owner_d = OWN_NONE;
        end

`ifdef MEM_ARB_RR_EN
        wait_cnt_d = 4'd0;
        rr_last_d  = rr_last_q;
        if (pick_if_s) begin
            rr_last_d = RR_IF;
        end else if (pick_d_s) begin
            rr_last_d = RR_D;
        end else begin
            rr_last_d = rr_last_q;
        end
`else
        // Counts refused fetch cycles, saturating at the guard threshold.
        if (!if_req || pick_if_s) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q >= MAX_WAIT_C) begin
            wait_cnt_d = MAX_WAIT_C;
        end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
`endif
    end

    // State registers; reset drops any response still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            wait_cnt_q <= 4'd0;
`ifdef MEM_ARB_RR_EN
            rr_last_q  <= RR_D;
`endif
        end else begin
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
`ifdef MEM_ARB_RR_EN
            rr_last_q  <= rr_last_d;
`endif
        end
    end

    assign if_rvalid = !rst && (owner_q == OWN_IF);
    assign d_rvalid  = !rst && (owner_q == OWN_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule
